// File: rtl/leds_pkg.sv
// rtl/leds_pkg.sv - shared channel-state encoding, width defaults and duty curve for leds_pwm_fade
package leds_pkg;

  localparam int BW_DEFAULT  = 4;
  localparam int MAX_DEFAULT = (1 << BW_DEFAULT) - 1;
  localparam int GAMMA_W     = 16;

  typedef enum logic [1:0] {
    ST_OFF,
    ST_RISING,
    ST_ON,
    ST_FALLING
  } chan_state_t;

  // Perceptual curve: b^2 / 2^bw, with full scale pinned so "fully on" stays solid.
  function automatic logic [GAMMA_W-1:0] gamma(input logic [GAMMA_W-1:0] b, input int bw);
    logic [2*GAMMA_W-1:0] sq;
    logic [GAMMA_W-1:0]   mx;
    mx = GAMMA_W'((32'd1 << bw) - 32'd1);
    sq = {{GAMMA_W{1'b0}}, b} * {{GAMMA_W{1'b0}}, b};
    if (b == mx) return mx;
    return GAMMA_W'(sq >> bw);
  endfunction

endpackage

// File: rtl/leds_fade_chan.sv
// rtl/leds_fade_chan.sv - one LED channel: brightness ramp and PWM comparator
// Duty curve selected by LEDS_PWM_GAMMA_EN (defined: gamma, undefined: linear).
module leds_fade_chan
  import leds_pkg::*;
#(
  parameter int BW   = BW_DEFAULT,
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          din_bit,
  input  logic          fade_tick,
  input  logic [BW-1:0] pwm_cnt,
  output logic          led
);

  localparam logic [BW-1:0] MAX    = {BW{1'b1}};
  localparam logic [BW:0]   STEP_W = (BW + 1)'(STEP);
  localparam logic [BW-1:0] STEP_B = BW'(STEP);

  logic [BW-1:0] b;
  logic [BW-1:0] d;
  logic [BW:0]   up_sum;
  chan_state_t   st;

  always_comb begin
    st = ST_OFF;
    if (din_bit) st = (b == MAX) ? ST_ON : ST_RISING;
    else         st = (b == '0)  ? ST_OFF : ST_FALLING;
  end

  // One extra bit so the saturating add can never wrap back to dim.
  assign up_sum = {1'b0, b} + STEP_W;

`ifdef LEDS_PWM_GAMMA_EN
  assign d = BW'(gamma(GAMMA_W'(b), BW));
`else
  assign d = b;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b   <= '0;
      led <= 1'b0;
    end else begin
      if (fade_tick) begin
        unique case (st)
          ST_RISING:  b <= (up_sum >= {1'b0, MAX}) ? MAX : up_sum[BW-1:0];
          ST_FALLING: b <= (b >= STEP_B) ? b - STEP_B : '0;
          default:    ;
        endcase
      end
      led <= (d == MAX) ? 1'b1 : (pwm_cnt < d);
    end
  end

endmodule

// File: rtl/leds_pwm_fade.sv
// rtl/leds_pwm_fade.sv - soft on/off PWM fader for the LED counter pattern
// Optional perceptual duty curve: define LEDS_PWM_GAMMA_EN.
module leds_pwm_fade
  import leds_pkg::*;
#(
  parameter int NLEDS    = 5,
  parameter int BW       = BW_DEFAULT,
  parameter int FADE_DIV = 65536,
  parameter int STEP     = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NLEDS-1:0] din,
  output logic [NLEDS-1:0] leds,
  output logic             fade_tick
);

  localparam int              PW         = $clog2(FADE_DIV);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(FADE_DIV - 1);

  logic [NLEDS-1:0] din_r;
  logic [BW-1:0]    pwm_cnt;
  logic [PW-1:0]    presc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_r   <= '0;
      pwm_cnt <= '0;
      presc   <= '0;
    end else begin
      din_r   <= din;
      pwm_cnt <= pwm_cnt + 1'b1;
      presc   <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
    end
  end

  // Decoded from the reset-cleared prescaler, so it drops with rstn immediately.
  assign fade_tick = (presc == PRESC_LAST);

  for (genvar i = 0; i < NLEDS; i++) begin : g_chan
    leds_fade_chan #(
      .BW   (BW),
      .STEP (STEP)
    ) u_chan (
      .clk       (clk),
      .rstn      (rstn),
      .din_bit   (din_r[i]),
      .fade_tick (fade_tick),
      .pwm_cnt   (pwm_cnt),
      .led       (leds[i])
    );
  end

endmodule

// File: tb/tb_leds_pwm_fade.sv
// tb/tb_leds_pwm_fade.sv - self-checking bench for leds_pwm_fade (LEDS_PWM_GAMMA_EN aware)
module tb_leds_pwm_fade;

  localparam int NL   = 5;
  localparam int BW   = 4;
  localparam int FD   = 16;
  localparam int STEP = 1;
  localparam int MAXV = 15;
  localparam int WIN  = 16;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic [NL-1:0] din  = '0;
  logic [NL-1:0] leds;
  logic          fade_tick;

  leds_pwm_fade #(.NLEDS(NL), .BW(BW), .FADE_DIV(FD), .STEP(STEP)) dut (
    .clk(clk), .rstn(rstn), .din(din), .leds(leds), .fade_tick(fade_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int duty(int b);
`ifdef LEDS_PWM_GAMMA_EN
    return (b == MAXV) ? MAXV : (b * b) / WIN;
`else
    return b;
`endif
  endfunction

  function automatic int win_high(int b);
    int d;
    d = duty(b);
    return (d == MAXV) ? WIN : d;
  endfunction

  // Reference model: brightness per channel, cycles since reset, expected pins.
  int            m_b [NL];
  logic [NL-1:0] m_din_r;
  logic [NL-1:0] m_led;
  int            m_cnt;

  always begin
    @(posedge clk);
    if (!rstn) begin
      m_cnt   = 0;
      m_din_r = '0;
      m_led   = '0;
      for (int i = 0; i < NL; i++) m_b[i] = 0;
    end else begin
      for (int i = 0; i < NL; i++)
        m_led[i] = (duty(m_b[i]) == MAXV) || ((m_cnt % WIN) < duty(m_b[i]));
      if ((m_cnt % FD) == FD - 1)
        for (int i = 0; i < NL; i++)
          m_b[i] = m_din_r[i] ? ((m_b[i] + STEP > MAXV) ? MAXV : m_b[i] + STEP)
                              : ((m_b[i] - STEP < 0) ? 0 : m_b[i] - STEP);
      m_din_r = din;
      m_cnt++;
      #1;
      if (rstn) begin
        chk("model_leds", int'(leds), int'(m_led));
        chk("model_tick", int'(fade_tick), int'((m_cnt % FD) == FD - 1));
      end
    end
  end

  task automatic wait_ticks(int n);
    for (int k = 0; k < n; k++) begin
      int c;
      c = 0;
      do begin
        @(posedge clk); #1; c++;
      end while (!fade_tick && c < 3 * FD);
      chk("tick_seen", int'(fade_tick), 1);
      if (!fade_tick) return;
    end
  endtask

  // Called right after a tick sample; counts highs over one full PWM window of the new b.
  task automatic measure(output logic [NL-1:0][4:0] cnt);
    cnt = '0;
    @(posedge clk); #1;
    for (int k = 0; k < WIN; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NL; i++) cnt[i] = cnt[i] + 5'(leds[i]);
    end
  endtask

  typedef struct packed {
    logic [NL-1:0]      din;
    logic [7:0]         ticks;
    logic [NL-1:0][4:0] b;
  } vec_t;

  function automatic vec_t mk(logic [NL-1:0] d, int ticks, int b0, int b3);
    vec_t v;
    v       = '0;
    v.din   = d;
    v.ticks = 8'(ticks);
    v.b[0]  = 5'(b0);
    v.b[3]  = 5'(b3);
    return v;
  endfunction

  vec_t               vecs [8];
  logic [NL-1:0][4:0] cnt;
  int                 cyc;
  int                 hi2;
  logic               seen;

  initial begin
    vecs[0] = mk(5'b00001, 1,  1,  0);
    vecs[1] = mk(5'b00001, 5,  7,  0);
    vecs[2] = mk(5'b01001, 2, 10,  2);
    vecs[3] = mk(5'b01001, 6, 15,  9);
    vecs[4] = mk(5'b01000, 3, 12, 13);
    vecs[5] = mk(5'b00000, 4,  7, 10);
    vecs[6] = mk(5'b00001, 1,  7,  8);
    vecs[7] = mk(5'b00000, 10, 0,  0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_leds", int'(leds), 0);
    chk("reset_tick", int'(fade_tick), 0);
    rstn = 1'b1;

    // Table: each measure window spends one further tick with the same din.
    for (int v = 0; v < 8; v++) begin
      din = vecs[v].din;
      wait_ticks(int'(vecs[v].ticks));
      measure(cnt);
      for (int i = 0; i < NL; i++)
        chk($sformatf("vec%0d_ch%0d_highs", v, i), int'(cnt[i]), win_high(int'(vecs[v].b[i])));
    end

    // Asynchronous reset mid-ramp while leds[0] is lit at b=9.
    din  = 5'b00001;
    seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(posedge clk); #1;
      seen = (m_b[0] == 9) && leds[0];
    end
    chk("midramp_reached", int'(seen), 1);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_leds", int'(leds), 0);
    chk("async_rst_tick", int'(fade_tick), 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    cyc  = 1;
    while (!fade_tick && cyc < 3 * FD) begin
      @(posedge clk); #1; cyc++;
    end
    chk("first_tick_cycle", cyc, 16);

    // Reversal at b=6: first tick above gave b=1, five more reach 6.
    wait_ticks(5);
    din = 5'b00000;
    wait_ticks(1);
    measure(cnt);
    chk("reversal_ch0_highs", int'(cnt[0]), win_high(5));

    // Glitch on din[2] strictly between ticks.
    wait_ticks(1);
    din = 5'b00100;
    repeat (3) begin @(posedge clk); #1; end
    din = 5'b00000;
    hi2 = 0;
    for (int k = 0; k < 3 * WIN; k++) begin
      @(posedge clk); #1;
      hi2 += int'(leds[2]);
    end
    chk("glitch_ch2_highs", hi2, 0);

    // Random patterns against the model, with one reset pulse in the middle.
    for (int s = 0; s < 80; s++) begin
      din = NL'($urandom);
      repeat ($urandom_range(1, 50)) @(posedge clk);
      #1;
      if (s == 40) begin
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
